// File: rtl/sr_frame_reader.sv
// sr_frame_reader
//   Streams frames out of the SR output FIFO as a valid/ready pixel stream
//   with start-of-frame, end-of-line and end-of-frame sideband flags.
//   The FIFO has a fixed one-cycle read latency, so reads are issued ahead
//   into a 2-entry buffer. This keeps one pixel per cycle flowing while
//   m_ready is held high.
//
// Ports
//   clk_r, rst_n      clock, asynchronous active-low reset
//   enable, abort     start/continue streaming, synchronous flush
//   data_count_r, din FIFO fill level and read data (valid 1 cycle after rd_fifo)
//   rd_fifo           FIFO read strobe
//   m_*               output pixel stream and sideband flags
//   frame_done        one-cycle pulse after the last pixel of a frame is taken
//   led_r             debug status; all zero unless SR_READER_DEBUG_EN is defined
//
// Build option
//   SR_READER_DEBUG_EN : led_r = {frame count mod 8, stall, rd_fifo, m_valid, state}
module sr_frame_reader #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int PIXEL_WIDTH  = 24,
    parameter int RD_THRESHOLD = 5
) (
    input  logic                   clk_r,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   abort,
    input  logic [9:0]             data_count_r,
    input  logic [PIXEL_WIDTH-1:0] din,
    output logic                   rd_fifo,
    output logic [PIXEL_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof,
    output logic                   frame_done,
    output logic [7:0]             led_r
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        FRAME_END = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PIXEL_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   inflight_q, inflight_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;

    logic       pop, push, rd, x_last, y_last, fill_ok;
    logic [2:0] occ;

    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = buf0_q;
    assign pop      = m_valid && m_ready;
    assign push     = inflight_q;
    assign x_last   = (x_q == XW'(WIDTH - 1));
    assign y_last   = (y_q == YW'(HEIGHT - 1));
    // Flags describe the head pixel. They are held low while nothing is presented.
    assign m_sof    = m_valid && (x_q == '0) && (y_q == '0);
    assign m_eol    = m_valid && x_last;
    assign m_eof    = m_valid && x_last && y_last;

    // Slots that will be committed after this cycle. The read issued now lands
    // while those entries are still held, so at most 2 may be committed.
    assign occ      = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign fill_ok  = (data_count_r > 10'(RD_THRESHOLD));
    // abort also blocks the read here, so no new read is in flight after a flush.
    assign rd       = (state_q == STREAM) && !abort && fill_ok && (occ < 3'd2);
    assign rd_fifo  = rd;

    assign frame_done = (state_q == FRAME_END);

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable) state_d = STREAM;
            STREAM:    if (pop && x_last && y_last) state_d = FRAME_END;
            FRAME_END: state_d = enable ? STREAM : IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Buffer, in-flight tracking and pixel position
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        inflight_d = rd;
        x_d        = x_q;
        y_d        = y_q;

        if (pop) begin
            buf0_d = buf1_q;
            if (push) begin
                if (cnt_q == 2'd1) buf0_d = din;
                else               buf1_d = din;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) buf0_d = din;
            else               buf1_d = din;
        end

        if (pop) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // A read landing during a flush is simply not counted.
        if (abort) begin
            cnt_d      = 2'd0;
            inflight_d = 1'b0;
            x_d        = '0;
            y_d        = '0;
        end
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

`ifdef SR_READER_DEBUG_EN
    logic [2:0] fcnt_q;
    logic       stall;

    assign stall = (state_q == STREAM) && !fill_ok;

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n)          fcnt_q <= 3'd0;
        else if (frame_done) fcnt_q <= fcnt_q + 3'd1;
    end

    assign led_r = {fcnt_q, stall, rd, m_valid, state_q};
`else
    assign led_r = 8'd0;
`endif

endmodule

// File: tb/tb_sr_frame_reader.sv
module tb_sr_frame_reader;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int PW   = 24;
    localparam int THR  = 5;
    localparam int NPIX = W * H;

    logic          clk_r = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic [9:0]    data_count_r = 10'd0;
    logic [PW-1:0] din = '0;
    logic          rd_fifo, m_valid, m_sof, m_eol, m_eof, frame_done;
    logic [PW-1:0] m_data;
    logic [7:0]    led_r;

    int checks = 0;
    int errors = 0;

    // Source FIFO contents. rd_ptr counts reads actually issued.
    logic [PW-1:0] fifo_mem [256];
    int            rd_ptr = 0;

    // Reference model: exp_ptr = index of the next pixel the stream must carry,
    // p = position of that pixel inside its frame (raster order).
    int exp_ptr = 0;
    int p       = 0;
    bit fd_exp  = 1'b0;
    bit idle_exp = 1'b0;

    sr_frame_reader #(
        .WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .RD_THRESHOLD(THR)
    ) dut (
        .clk_r(clk_r), .rst_n(rst_n), .enable(enable), .abort(abort),
        .data_count_r(data_count_r), .din(din), .rd_fifo(rd_fifo),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .frame_done(frame_done), .led_r(led_r)
    );

    always #5 clk_r = ~clk_r;

    // FIFO with one-cycle read latency
    always @(posedge clk_r) begin
        if (rd_fifo) begin
            din    <= fifo_mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Streams cycles against the model. target>0: stop after that many pops
    // (timeout counts as an error); target==0: run exactly max_cyc cycles.
    task automatic test_stream(input int mode, input int target, input int max_cyc, input bit burst);
        int pops = 0;
        int cyc  = 0;
        bit done = 1'b0;
        logic [2:0] fl_exp;
        while (!done) begin
            @(posedge clk_r); #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: begin
                    m_ready      = 1'($urandom_range(0, 1));
                    data_count_r = 10'($urandom_range(3, 9));
                end
            endcase
            @(negedge clk_r);
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL frame_done: got %b expected %b (p=%0d)", frame_done, fd_exp, p);
            end
            if (m_valid === 1'b1) begin
                checks++;
                if (m_data !== fifo_mem[exp_ptr % 256]) begin
                    errors++;
                    $display("FAIL pixel_data: got %h expected %h (idx %0d)", m_data, fifo_mem[exp_ptr % 256], exp_ptr);
                end
                fl_exp = {p == 0, (p % W) == W - 1, p == NPIX - 1};
                checks++;
                if ({m_sof, m_eol, m_eof} !== fl_exp) begin
                    errors++;
                    $display("FAIL flags: got sof/eol/eof %b expected %b (p=%0d)", {m_sof, m_eol, m_eof}, fl_exp, p);
                end
            end
            checks++;
            if ((rd_ptr - exp_ptr > 2) || (m_valid === 1'b1 && rd_ptr <= exp_ptr)) begin
                errors++;
                $display("FAIL occupancy: got %0d outstanding (valid=%b) expected 0..2", rd_ptr - exp_ptr, m_valid);
            end
            checks++;
            if (rd_fifo === 1'b1 && (data_count_r <= 10'(THR) || idle_exp)) begin
                errors++;
                $display("FAIL rd_gate: got rd_fifo=1 expected 0 (count=%0d idle=%b)", data_count_r, idle_exp);
            end
            checks++;
            if (led_r !== 8'd0) begin
                errors++;
                $display("FAIL led_r: got %h expected 00", led_r);
            end
            if (burst && pops > 0 && pops < NPIX) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL burst: got m_valid=%b expected 1 after %0d pops", m_valid, pops);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                fd_exp  = (p == NPIX - 1);
                exp_ptr = exp_ptr + 1;
                p       = (p + 1) % NPIX;
                pops++;
            end else begin
                fd_exp = 1'b0;
            end
            cyc++;
            if (target > 0 && pops >= target) done = 1'b1;
            else if (cyc >= max_cyc) begin
                done = 1'b1;
                if (target > 0) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: got %0d pops expected %0d", pops, target);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_r);
        @(negedge clk_r);
        checks++;
        if ({rd_fifo, m_valid, frame_done, led_r} !== 11'd0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got rd=%b v=%b fd=%b led=%h data=%h expected all 0",
                     rd_fifo, m_valid, frame_done, led_r, m_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_threshold();
        enable       = 1'b1;
        m_ready      = 1'b1;
        data_count_r = 10'(THR);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_r);
            checks++;
            if (rd_fifo !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL thr_stall: got rd=%b v=%b expected 0 0", rd_fifo, m_valid);
            end
        end
        // First frame carries pixels 1..8.
        for (int i = 0; i < NPIX; i++) fifo_mem[(rd_ptr + i) % 256] = PW'(i + 1);
        @(posedge clk_r); #1;
        data_count_r = 10'(THR + 1);
        @(negedge clk_r);
        checks++;
        if (rd_fifo !== 1'b1) begin
            errors++;
            $display("FAIL thr_release: got rd_fifo=%b expected 1", rd_fifo);
        end
    endtask

    task automatic test_basic_frame();
        data_count_r = 10'd20;
        test_stream(0, NPIX + 2, 100, 1'b1);
    endtask

    task automatic test_toggle_ready();
        test_stream(1, 2 * NPIX, 300, 1'b0);
        m_ready = 1'b1;
    endtask

    task automatic test_abort();
        test_stream(0, 3, 100, 1'b0);
        @(posedge clk_r); #1;
        abort = 1'b1;
        @(posedge clk_r); #1;
        abort   = 1'b0;
        exp_ptr = rd_ptr;
        p       = 0;
        fd_exp  = 1'b0;
        @(negedge clk_r);
        checks++;
        if (m_valid !== 1'b0 || rd_fifo !== 1'b0) begin
            errors++;
            $display("FAIL abort_flush: got v=%b rd=%b expected 0 0", m_valid, rd_fifo);
        end
        test_stream(0, NPIX + 1, 200, 1'b0);
    endtask

    task automatic test_reset_mid();
        test_stream(0, 3, 100, 1'b0);
        @(posedge clk_r); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_fifo, m_valid, m_sof, m_eol, m_eof, frame_done, led_r} !== 14'd0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_async: got rd=%b v=%b flags=%b fd=%b led=%h data=%h expected all 0",
                     rd_fifo, m_valid, {m_sof, m_eol, m_eof}, frame_done, led_r, m_data);
        end
        @(negedge clk_r);
        rst_n   = 1'b1;
        exp_ptr = rd_ptr;
        p       = 0;
        fd_exp  = 1'b0;
        test_stream(0, NPIX + 1, 200, 1'b0);
    endtask

    task automatic test_enable_drop();
        test_stream(0, 2, 100, 1'b0);
        enable = 1'b0;
        test_stream(0, NPIX - p, 100, 1'b0);
        idle_exp = 1'b1;
        test_stream(0, 0, 10, 1'b0);
        idle_exp = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_drain: got m_valid=%b expected 0", m_valid);
        end
        enable = 1'b1;
        test_stream(0, NPIX, 200, 1'b0);
    endtask

    task automatic test_random();
        test_stream(2, 3 * NPIX, 3000, 1'b0);
        data_count_r = 10'd20;
        m_ready      = 1'b1;
        test_stream(0, NPIX, 200, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fifo_mem[i] = PW'($urandom);
        test_reset();
        test_threshold();
        test_basic_frame();
        test_toggle_ready();
        test_abort();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
